// File: rtl/pwm_meter.sv
// PWM period / high-time meter with stuck-high / stuck-low detection.
// Optional 4-sample averaging of the outputs is enabled by defining PWM_METER_AVG_EN.
module pwm_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS,
        ST_STUCK
    } state_t;

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic             w_rise;
    logic             w_timeout;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_timeout = (r_per_cnt == TMO) && !w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Both counters restart at 1 on the rise cycle so a synchronous TP/TH input reads back exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (clr) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (w_rise) begin
            r_per_cnt <= CNT_W'(1);
            r_hi_cnt  <= CNT_W'(1);
        end else begin
            if (r_per_cnt != TMO) begin
                r_per_cnt <= r_per_cnt + 1'b1;
            end
            if (r_s2 && (r_hi_cnt != TMO)) begin
                r_hi_cnt <= r_hi_cnt + 1'b1;
            end
        end
    end

`ifdef PWM_METER_AVG_EN
    logic [CNT_W+1:0] r_sum_p;
    logic [CNT_W+1:0] r_sum_h;
    logic [1:0]       r_smp;
    logic [CNT_W+1:0] w_sum_p;
    logic [CNT_W+1:0] w_sum_h;

    assign w_sum_p = r_sum_p + {2'b00, r_per_cnt};
    assign w_sum_h = r_sum_h + {2'b00, r_hi_cnt};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
`ifdef PWM_METER_AVG_EN
            r_sum_p    <= '0;
            r_sum_h    <= '0;
            r_smp      <= '0;
`endif
        end else begin
            meas_valid <= 1'b0;
            if (clr) begin
                r_state    <= ST_IDLE;
                period_out <= '0;
                high_out   <= '0;
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
`ifdef PWM_METER_AVG_EN
                r_sum_p    <= '0;
                r_sum_h    <= '0;
                r_smp      <= '0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE, ST_MEAS: begin
                        if (w_rise) begin
                            r_state    <= ST_MEAS;
                            stuck_high <= 1'b0;
                            stuck_low  <= 1'b0;
                            if (r_state == ST_MEAS) begin
`ifdef PWM_METER_AVG_EN
                                // Fourth sample publishes the truncated mean and restarts the sums.
                                if (r_smp == 2'd3) begin
                                    period_out <= w_sum_p[CNT_W+1:2];
                                    high_out   <= w_sum_h[CNT_W+1:2];
                                    meas_valid <= 1'b1;
                                    r_sum_p    <= '0;
                                    r_sum_h    <= '0;
                                end else begin
                                    r_sum_p <= w_sum_p;
                                    r_sum_h <= w_sum_h;
                                end
                                r_smp <= r_smp + 1'b1;
`else
                                period_out <= r_per_cnt;
                                high_out   <= r_hi_cnt;
                                meas_valid <= 1'b1;
`endif
                            end
                        end else if (w_timeout) begin
                            r_state    <= ST_STUCK;
                            stuck_high <= r_s2;
                            stuck_low  <= ~r_s2;
`ifdef PWM_METER_AVG_EN
                            r_sum_p    <= '0;
                            r_sum_h    <= '0;
                            r_smp      <= '0;
`endif
                        end
                    end
                    ST_STUCK: begin
                        if (w_rise) begin
                            r_state    <= ST_MEAS;
                            stuck_high <= 1'b0;
                            stuck_low  <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    a_stuck_exclusive: assert property (@(posedge clk) disable iff (rst) !(stuck_high && stuck_low));

endmodule

// File: tb/tb_pwm_meter.sv
// Scoreboard bench for pwm_meter: stimulus pushes expected measurements, a monitor pops them on meas_valid.
// Expectations follow PWM_METER_AVG_EN when the bench is built with that macro.
module tb_pwm_meter;

    localparam int CNT_W = 16;
    localparam int TMO   = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic             clr;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;

    pwm_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .clr        (clr),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
    } meas_t;

    meas_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    armed = 1'b0;
    int    prev_tp = 0;
    int    prev_th = 0;
    int    last_p = 0;
    int    last_h = 0;
    int    acc_p = 0;
    int    acc_h = 0;
    int    acc_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void reset_acc();
        acc_p = 0;
        acc_h = 0;
        acc_n = 0;
    endfunction

    function automatic void expect_out(input int p, input int h);
        meas_t e;
        e.p = p;
        e.h = h;
        exp_q.push_back(e);
        last_p = p;
        last_h = h;
    endfunction

    function automatic void push_meas(input int p, input int h);
`ifdef PWM_METER_AVG_EN
        acc_p += p;
        acc_h += h;
        acc_n++;
        if (acc_n == 4) begin
            expect_out(acc_p >> 2, acc_h >> 2);
            reset_acc();
        end
`else
        expect_out(p, h);
`endif
    endfunction

    // A rise measures the pulse before it, provided the meter was already armed.
    function automatic void rise_event(input int tp, input int th);
        if (armed) push_meas(prev_tp, prev_th);
        prev_tp = tp;
        prev_th = th;
        armed   = 1'b1;
    endfunction

    task automatic pulse(input int tp, input int th);
        rise_event(tp, th);
        pwm_in = 1'b1;
        repeat (th) @(negedge clk);
        pwm_in = 1'b0;
        repeat (tp - th) @(negedge clk);
    endtask

    // Rise at the pin; clr is raised so it coincides with the synchronised rise two edges later.
    task automatic pulse_clr(input int tp, input int th);
        pwm_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        armed = 1'b0;
        reset_acc();
        last_p = 0;
        last_h = 0;
        repeat (th - 3) @(negedge clk);
        pwm_in = 1'b0;
        repeat (tp - th) @(negedge clk);
    endtask

    task automatic wait_stuck(input bit want_high, input int lo, input int hi, input string name);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < hi + 20) begin
            @(negedge clk);
            n++;
            if ((want_high ? stuck_high : stuck_low) === 1'b1) seen = 1'b1;
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        check({name, "_latency_ok"}, 32'((n >= lo) && (n <= hi)), 32'd1);
    endtask

    always @(negedge clk) begin
        meas_t e;
        if (rst === 1'b0 && meas_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_meas_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("period_out", 32'(period_out), 32'(e.p));
                check("high_out", 32'(high_out), 32'(e.h));
            end
        end
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        clr    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period_out", 32'(period_out), 32'd0);
        check("rst_high_out", 32'(high_out), 32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check("rst_stuck_high", 32'(stuck_high), 32'd0);
        check("rst_stuck_low", 32'(stuck_low), 32'd0);
        rst = 1'b0;

        wait_stuck(1'b0, 996, 1006, "stuck_low_idle");
        check("idle_stuck_high", 32'(stuck_high), 32'd0);
        check("idle_period_out", 32'(period_out), 32'd0);

        pulse(500, 50);
        check("restart_stuck_low_clear", 32'(stuck_low), 32'd0);
        repeat (4) pulse(500, 50);

        repeat (3) pulse(100, 99);
        repeat (3) pulse(100, 1);
        check("run_stuck_high", 32'(stuck_high), 32'd0);
        check("run_stuck_low", 32'(stuck_low), 32'd0);

        rise_event(0, 0);
        pwm_in = 1'b1;
        wait_stuck(1'b1, 996, 1008, "stuck_high");
        check("stuck_high_low_flag", 32'(stuck_low), 32'd0);
        check("stuck_hold_period", 32'(period_out), 32'(last_p));
        check("stuck_hold_high", 32'(high_out), 32'(last_h));
        armed = 1'b0;
        reset_acc();

        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        pulse(300, 100);
        check("recover_stuck_high", 32'(stuck_high), 32'd0);
        check("recover_stuck_low", 32'(stuck_low), 32'd0);
        repeat (2) pulse(300, 100);

        pulse_clr(300, 100);
        check("clr_period_out", 32'(period_out), 32'd0);
        check("clr_high_out", 32'(high_out), 32'd0);
        check("clr_stuck_low", 32'(stuck_low), 32'd0);

        pulse(100, 10);
        pulse(102, 11);
        pulse(104, 12);
        pulse(106, 13);
        pulse(200, 30);
        pulse(200, 30);

        repeat (10) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pwm_meter.md
Name: pwm_meter

Overview:
- Downstream stage of the PWM generator. Measures an incoming PWM waveform: period and high time, both in clk cycles.
- Flags stuck-high and stuck-low lines.
- Used for on-board self-check of pwm_out and for the debug readout logic.
- Input is treated as asynchronous and synchronised internally.

Parameters:
- CNT_W, 16: width of the period/high counters and outputs.
- TIMEOUT, 65535: cycles without a rising edge before a stuck condition is declared. Legal range 2..2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- pwm_in  in  1  PWM signal under measurement, asynchronous.
- clr  in  1  synchronous clear, active-high: return to IDLE and clear all outputs.
- period_out  out  CNT_W  last measured period (rising edge to rising edge), in cycles.
- high_out  out  CNT_W  last measured high time, in cycles.
- meas_valid  out  1  one-cycle pulse when period_out/high_out update.
- stuck_high  out  1  level; no edge for TIMEOUT cycles while the line is high.
- stuck_low  out  1  level; no edge for TIMEOUT cycles while the line is low.

Behaviour:
- Reset (rst=1, async): all outputs 0, all counters 0, FSM=IDLE, synchroniser flops 0.
- Synchroniser: s1<=pwm_in, s2<=s1, s3<=s2. rise=s2&~s3. All logic uses s2 and rise only.
- per_cnt: on a rise cycle, per_cnt<=1; otherwise per_cnt<=per_cnt+1, saturating at TIMEOUT.
- hi_cnt: on a rise cycle, hi_cnt<=1; otherwise it increments while s2=1 and holds while s2=0. It saturates at TIMEOUT.
- FSM states:
  - IDLE: waiting for the first rise. On rise go to MEAS. No meas_valid is issued; the counters are only armed.
  - MEAS: on rise, latch period_out<=per_cnt and high_out<=hi_cnt, set meas_valid=1 for exactly the next cycle, clear stuck_high/stuck_low, and stay in MEAS.
  - MEAS timeout: when per_cnt==TIMEOUT and there is no rise, go to STUCK. Set stuck_high=s2 and stuck_low=~s2. period_out and high_out hold their last values.
  - STUCK: on rise, clear both stuck flags and go to MEAS with the counters armed (same as leaving IDLE). No meas_valid on this edge.
- IDLE timeout: in IDLE the same TIMEOUT check applies and leads to STUCK. A constant line after reset is therefore flagged.
- Latency: pwm_in rising at the pin leads to meas_valid 3–4 clk later (2-flop sync, edge register, output register).
- Reference timing: for a synchronous ideal input with rises TP cycles apart and high time TH (0<TH<TP), period_out=TP and high_out=TH exactly.
- Boundary rules:
  - clr together with rise: clr wins, FSM=IDLE, outputs 0.
  - A pulse shorter than 1 clk may be missed; this is accepted, no error flag.
  - 100% duty leads to stuck_high after TIMEOUT. 0% duty leads to stuck_low.
  - stuck_high and stuck_low are never 1 together.
  - Reset asserted mid-measurement discards partial counts.

Optional Feature:
- Macro: PWM_METER_AVG_EN.
- Defined: four consecutive measurements are accumulated in CNT_W+2-bit sums.
  - Every 4th measurement, period_out=sum_p>>2 and high_out=sum_h>>2 (truncating), and meas_valid pulses once.
  - The sample counter and sums are reset by rst, clr and entry to STUCK.
- Not defined: every measurement is output directly as described above, with no accumulator logic.

Test Plan:
- Drive ideal PWM with period 500 and duty 50 (the generator with PERIOD=500, DUTY=50) -> first meas_valid after the 2nd rise, then period_out=500 and high_out=50 on every pulse, one pulse per 500 cycles.
- Change the input to period 100, high 99, then period 100, high 1 -> period_out=100 with high_out=99, then high_out=1. No stuck flags.
- TIMEOUT=1000, pwm_in held at 1 after one rise -> stuck_high=1 and stuck_low=0 within 1000±4 cycles, with outputs holding the previous values. Restart PWM -> flags clear on the first rise, meas_valid on the second.
- After reset, hold pwm_in at 0 with TIMEOUT=1000 -> stuck_low=1 at about cycle 1000 and meas_valid never asserted.
- Assert clr in the same cycle as a detected rise mid-stream -> all outputs 0, no meas_valid. Measurement resumes after two further rises.
- With PWM_METER_AVG_EN, drive periods 100, 102, 104, 106 with high times 10, 11, 12, 13 -> a single meas_valid with period_out=103 and high_out=11.
